serial_frame_receiver: RTL and testbench



---
 rtl/serial_rx_pkg.sv | 11 +
 rtl/rx_shift_reg.sv | 21 ++
 rtl/serial_frame_receiver.sv | 79 +++++++
 tb/tb_serial_frame_receiver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding.
package serial_rx_pkg;

   // 2'd3 is never entered; the FSM treats it like RX_IDLE.
   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_DATA = 2'd1,
      RX_STOP = 2'd2
   } rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// WIDTH-bit right-shift register; serial bits enter at the MSB so that after
// WIDTH shifts the first bit received (the LSB of the word) sits in bit 0.
module rx_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             shift,
   input  logic             din,
   output logic [WIDTH-1:0] dout
);

   // Shift one bit in from the top whenever enabled.
   always_ff @(posedge Clock) begin
      if (Reset)
         dout <= '0;
      else if (shift)
         dout <= {din, dout[WIDTH-1:1]};
   end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial-in / parallel-out frame receiver: start bit, WIDTH data bits LSB
// first, stop bit. Good frames update Q with a one-cycle Valid pulse; a bad
// stop bit discards the word and pulses FrameErr.
module serial_frame_receiver
   import serial_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             w,
   input  logic             En,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   output logic             FrameErr,
   output logic             Busy
);

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   rx_state_t        state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;

   // Data bits are captured only on strobed edges while in the data phase.
   rx_shift_reg #(.WIDTH(WIDTH)) u_shreg (
      .Clock (Clock),
      .Reset (Reset),
      .shift (En && (state == RX_DATA)),
      .din   (w),
      .dout  (shreg)
   );

   // Frame FSM, bit counter and registered outputs; pulses clear every edge.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= RX_IDLE;
         count    <= '0;
         Q        <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         if (En) begin
            case (state)
               RX_DATA: begin
                  // Count holds at the last index instead of wrapping.
                  if (count == LAST)
                     state <= RX_STOP;
                  else
                     count <= count + 1'b1;
               end
               RX_STOP: begin
                  if (w) begin
                     Q     <= shreg;
                     Valid <= 1'b1;
                  end else begin
                     FrameErr <= 1'b1;
                  end
                  state <= RX_IDLE;
                  Busy  <= 1'b0;
               end
               default: begin
                  // Idle (and the unused encoding): any 0 is a start bit.
                  if (!w) begin
                     state <= RX_DATA;
                     count <= '0;
                     Busy  <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver (WIDTH=4): frame-level
// reference model compared every cycle, plus literal expectations per scenario.
module tb_serial_frame_receiver;

   localparam int W = 4;

   logic         Clock = 1'b0;
   logic         Reset = 1'b0;
   logic         w     = 1'b1;
   logic         En    = 1'b0;
   logic [W-1:0] Q;
   logic         Valid, FrameErr, Busy;

   serial_frame_receiver #(.WIDTH(W)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .w        (w),
      .En       (En),
      .Q        (Q),
      .Valid    (Valid),
      .FrameErr (FrameErr),
      .Busy     (Busy)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: pos = -1 idle, 0..W-1 = data bits collected, W = expecting stop.
   int           mpos  = -1;
   logic [W-1:0] mbits = '0;
   logic [W-1:0] m_q   = '0;
   logic         m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0;

   always @(posedge Clock) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (Reset) begin
         mpos = -1; mbits = '0; m_q = '0; m_busy = 1'b0;
      end else if (En) begin
         if (mpos < 0) begin
            if (!w) mpos = 0;
         end else if (mpos < W) begin
            mbits[mpos] = w;
            mpos++;
         end else begin
            if (w) begin m_q = mbits; m_valid = 1'b1; end
            else m_err = 1'b1;
            mpos = -1;
         end
         m_busy = (mpos >= 0);
      end
   end

   // Per-cycle compare plus event statistics for the literal checks.
   bit chk_en = 1'b0;
   int cyc = 0, valid_cnt = 0, err_cnt = 0, busy_cyc = 0;
   int v_last = -1, v_gap = -1;

   always @(negedge Clock) begin
      if (chk_en) begin
         cyc++;
         chk("Q", 32'(Q), 32'(m_q));
         chk("Valid", 32'(Valid), 32'(m_valid));
         chk("FrameErr", 32'(FrameErr), 32'(m_err));
         chk("Busy", 32'(Busy), 32'(m_busy));
         if (Busy === 1'b1) busy_cyc++;
         if (FrameErr === 1'b1) err_cnt++;
         if (Valid === 1'b1) begin
            valid_cnt++;
            if (v_last >= 0) v_gap = cyc - v_last;
            v_last = cyc;
         end
      end
   end

   task automatic step(input logic en_v, input logic w_v, input logic rst_v = 1'b0);
      En = en_v; w = w_v; Reset = rst_v;
      @(posedge Clock);
      #1;
   endtask

   // Start, WIDTH data bits LSB first, stop; gap En=0 cycles after each bit
   // with w toggling to prove it is ignored.
   task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input int gap);
      logic [W+1:0] bits;
      bits = {stop_b, d, 1'b0};
      for (int i = 0; i < W + 2; i++) begin
         step(1'b1, bits[i]);
         for (int g = 0; g < gap; g++) step(1'b0, g[0] ^ bits[i]);
      end
   endtask

   int v0, e0;

   initial begin
      // 1. Reset, then idle line.
      step(1'b0, 1'b1, 1'b1);
      chk_en = 1'b1;
      chk("rst_Q", 32'(Q), 32'h0);
      chk("rst_Busy", 32'(Busy), 32'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      chk("idle_valid_cnt", 32'(valid_cnt), 32'd0);
      chk("idle_busy_cyc", 32'(busy_cyc), 32'd0);

      // 2. Good frame 4'hD.
      busy_cyc = 0; v0 = valid_cnt;
      send_frame(4'hD, 1'b1, 0);
      chk("t2_Valid_now", 32'(Valid), 32'h1);
      chk("t2_Q", 32'(Q), 32'hD);
      step(1'b1, 1'b1);
      chk("t2_Valid_drop", 32'(Valid), 32'h0);
      chk("t2_busy_cyc", 32'(busy_cyc), 32'd5);
      chk("t2_valid_cnt", 32'(valid_cnt - v0), 32'd1);

      // 3. Bad stop bit.
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(4'hF, 1'b0, 0);
      chk("t3_FrameErr_now", 32'(FrameErr), 32'h1);
      step(1'b1, 1'b1);
      chk("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
      chk("t3_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("t3_Q_hold", 32'(Q), 32'hD);

      // 4. Frame 4'hA with En gaps and a toggling line.
      v0 = valid_cnt;
      send_frame(4'hA, 1'b1, 3);
      chk("t4_Q", 32'(Q), 32'hA);
      chk("t4_valid_cnt", 32'(valid_cnt - v0), 32'd1);

      // 5. Back-to-back frames 4'h3, 4'hC.
      step(1'b1, 1'b1);
      v0 = valid_cnt;
      send_frame(4'h3, 1'b1, 0);
      chk("t5_Q_first", 32'(Q), 32'h3);
      send_frame(4'hC, 1'b1, 0);
      chk("t5_Q_second", 32'(Q), 32'hC);
      step(1'b1, 1'b1);
      chk("t5_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      chk("t5_gap", 32'(v_gap), 32'd6);

      // 6. Reset mid-frame (En=1 alongside), then a good frame.
      v0 = valid_cnt; e0 = err_cnt;
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      chk("t6_Busy", 32'(Busy), 32'h0);
      chk("t6_Q", 32'(Q), 32'h0);
      chk("t6_Valid", 32'(Valid), 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      chk("t6_no_pulse", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);
      send_frame(4'h5, 1'b1, 0);
      chk("t6_Q5", 32'(Q), 32'h5);
      chk("t6_Valid5", 32'(Valid), 32'h1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
